// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single data-memory port: core MEM stage vs debug/loader.
// Core has priority; a starvation counter forces a one-cycle debug grant.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            core_req,
    input  logic            core_wren,
    input  logic [AW-1:0]   core_addr,
    input  logic [XLEN-1:0] core_wdata,
    input  logic [3:0]      core_byteena,
    output logic            core_stall,
    output logic [XLEN-1:0] core_rdata,

    input  logic            dbg_req,
    input  logic            dbg_wren,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [XLEN-1:0] dbg_rdata,

    output logic [AW-1:0]   mem_address,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_byteena,
    output logic            mem_wren,
    input  logic [XLEN-1:0] mem_q
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [3:0] starve_eff;
    logic       dbg_win;
    logic       core_win;
    logic       rd_valid;
    logic       rd_dbg;
    logic       dbg_ret;

    // The reset cycle arbitrates as if the counter were already cleared.
    assign starve_eff = reset ? 4'd0 : starve_cnt;

    assign dbg_win  = dbg_req && (!core_req || (starve_eff == STARVE_LIM));
    assign core_win = core_req && !dbg_win;

    assign dbg_gnt    = dbg_win;
    assign core_stall = core_req && dbg_win;

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_byteena = 4'h0;
        mem_wren    = 1'b0;
        unique case (1'b1)
            dbg_win: begin
                mem_address = dbg_addr;
                mem_data    = dbg_wdata;
                mem_byteena = 4'hF;
                mem_wren    = dbg_wren;
            end
            core_win: begin
                mem_address = core_addr;
                mem_data    = core_wdata;
                mem_byteena = core_byteena;
                mem_wren    = core_wren;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (dbg_win || !dbg_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Remember who issued the load so next cycle's mem_q goes to them.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_dbg   <= 1'b0;
        end else begin
            rd_valid <= (dbg_win && !dbg_wren) || (core_win && !core_wren);
            rd_dbg   <= dbg_win;
        end
    end

    // Gating with reset drops a debug read whose return lands in a reset cycle.
    assign dbg_ret    = rd_valid && rd_dbg && !reset;
    assign dbg_rvalid = dbg_ret;
    assign dbg_rdata  = dbg_ret ? mem_q : '0;
    assign core_rdata = dbg_ret ? '0 : mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req, core_wren;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_byteena;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_wren;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_address, mem_data;
    logic [3:0]  mem_byteena;
    logic        mem_wren;
    logic [31:0] mem_q;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.XLEN(32), .AW(32), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_wren(core_wren),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_byteena(core_byteena),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_wren(dbg_wren),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_byteena(mem_byteena), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_wren = 0; core_addr = 0;
        core_wdata = 0; core_byteena = 0;
        dbg_req = 0; dbg_wren = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); mem_q = 32'h1111_2222;
        cyc(); cyc();
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %0b want 0", dbg_rvalid);
        end
        checks++;
        if (dbg_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata);
        end
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== 32'h0 || mem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle_port: got wren=%0b addr=%h data=%h want 0/0/0",
                     mem_wren, mem_address, mem_data);
        end
        checks++;
        if (core_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_grant: got stall=%0b gnt=%0b want 0/0",
                     core_stall, dbg_gnt);
        end
        reset = 0;
        cyc();
    endtask

    task automatic test_core_load();
        core_req = 1; core_wren = 0; core_addr = 32'h10; core_byteena = 4'hF;
        #1;
        checks++;
        if (mem_address !== 32'h10 || mem_wren !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL core_load_issue: got addr=%h wren=%0b stall=%0b want 10/0/0",
                     mem_address, mem_wren, core_stall);
        end
        cyc();
        idle(); mem_q = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (core_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL core_load_data: got %h want deadbeef", core_rdata);
        end
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL core_load_no_dbg: got rvalid=%0b rdata=%h want 0/0",
                     dbg_rvalid, dbg_rdata);
        end
        cyc();
    endtask

    task automatic test_dbg_store();
        dbg_req = 1; dbg_wren = 1; dbg_addr = 32'h20; dbg_wdata = 32'h5;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_byteena !== 4'hF) begin
            errors++;
            $display("FAIL dbg_store_grant: got gnt=%0b wren=%0b be=%h want 1/1/f",
                     dbg_gnt, mem_wren, mem_byteena);
        end
        checks++;
        if (mem_address !== 32'h20 || mem_data !== 32'h5) begin
            errors++;
            $display("FAIL dbg_store_port: got addr=%h data=%h want 20/5",
                     mem_address, mem_data);
        end
        cyc();
        idle(); mem_q = 32'h0000_1234;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL dbg_store_no_rvalid: got rvalid=%0b rdata=%h want 0/0",
                     dbg_rvalid, dbg_rdata);
        end
        checks++;
        if (core_rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL dbg_store_core_rdata: got %h want 1234", core_rdata);
        end
        cyc();
    endtask

    // Both masters storing; expects debug on every n-th cycle counted from start.
    task automatic run_contention(input string name, input int ncyc, input int period);
        logic exp_d;
        for (int i = 1; i <= ncyc; i++) begin
            exp_d = (i % period == 0);
            #1;
            checks++;
            if (dbg_gnt !== exp_d || core_stall !== exp_d) begin
                errors++;
                $display("FAIL %s_grant cyc %0d: got gnt=%0b stall=%0b want %0b/%0b",
                         name, i, dbg_gnt, core_stall, exp_d, exp_d);
            end
            checks++;
            if (mem_address !== (exp_d ? 32'h200 : 32'h100) ||
                mem_byteena !== (exp_d ? 4'hF : 4'h3)) begin
                errors++;
                $display("FAIL %s_port cyc %0d: got addr=%h be=%h want %h/%h",
                         name, i, mem_address, mem_byteena,
                         exp_d ? 32'h200 : 32'h100, exp_d ? 4'hF : 4'h3);
            end
            cyc();
        end
    endtask

    task automatic both_store();
        core_req = 1; core_wren = 1; core_addr = 32'h100;
        core_wdata = 32'hAA; core_byteena = 4'h3;
        dbg_req = 1; dbg_wren = 1; dbg_addr = 32'h200; dbg_wdata = 32'hBB;
    endtask

    task automatic test_starve();
        both_store();
        run_contention("starve", 10, 5);
        idle();
        cyc();
    endtask

    task automatic test_back_to_back();
        dbg_req = 1; dbg_wren = 0; dbg_addr = 32'h40;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1 || mem_address !== 32'h40 ||
            mem_wren !== 1'b0 || mem_byteena !== 4'hF) begin
            errors++;
            $display("FAIL b2b_dbg_issue: got gnt=%0b addr=%h wren=%0b be=%h want 1/40/0/f",
                     dbg_gnt, mem_address, mem_wren, mem_byteena);
        end
        cyc();
        idle();
        core_req = 1; core_wren = 0; core_addr = 32'h44; core_byteena = 4'h5;
        mem_q = 32'h4040_4040;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h4040_4040) begin
            errors++;
            $display("FAIL b2b_dbg_return: got rvalid=%0b rdata=%h want 1/40404040",
                     dbg_rvalid, dbg_rdata);
        end
        checks++;
        if (core_rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_core_masked: got %h want 0", core_rdata);
        end
        checks++;
        if (mem_address !== 32'h44 || mem_byteena !== 4'h5 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_core_issue: got addr=%h be=%h stall=%0b want 44/5/0",
                     mem_address, mem_byteena, core_stall);
        end
        cyc();
        idle(); mem_q = 32'h4444_4444;
        #1;
        checks++;
        if (core_rdata !== 32'h4444_4444) begin
            errors++; $display("FAIL b2b_core_return: got %h want 44444444", core_rdata);
        end
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_dbg_done: got rvalid=%0b rdata=%h want 0/0",
                     dbg_rvalid, dbg_rdata);
        end
        cyc();
    endtask

    task automatic test_reset_inflight();
        dbg_req = 1; dbg_wren = 0; dbg_addr = 32'h80;
        cyc();
        idle(); reset = 1; mem_q = 32'h9999_9999;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL inflight_reset_cycle: got rvalid=%0b rdata=%h want 0/0",
                     dbg_rvalid, dbg_rdata);
        end
        checks++;
        if (core_rdata !== 32'h9999_9999) begin
            errors++; $display("FAIL inflight_core_rdata: got %h want 99999999", core_rdata);
        end
        cyc();
        reset = 0;
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            errors++; $display("FAIL inflight_after_reset: got %0b want 0", dbg_rvalid);
        end
        cyc();
    endtask

    task automatic test_reset_counter();
        both_store();
        run_contention("pre_reset", 4, 5);
        reset = 1;
        #1;
        checks++;
        if (dbg_gnt !== 1'b0 || core_stall !== 1'b0 || mem_address !== 32'h100) begin
            errors++;
            $display("FAIL reset_cycle_arb: got gnt=%0b stall=%0b addr=%h want 0/0/100",
                     dbg_gnt, core_stall, mem_address);
        end
        cyc();
        reset = 0;
        run_contention("post_reset", 5, 5);
        idle();
        cyc();
    endtask

    task automatic test_starve_drop();
        both_store();
        run_contention("drop_pre", 3, 5);
        dbg_req = 0;
        #1;
        checks++;
        if (dbg_gnt !== 1'b0 || mem_address !== 32'h100) begin
            errors++;
            $display("FAIL drop_gap: got gnt=%0b addr=%h want 0/100", dbg_gnt, mem_address);
        end
        cyc();
        dbg_req = 1;
        run_contention("drop_post", 5, 5);
        idle();
        #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== 32'h0 || mem_data !== 32'h0) begin
            errors++;
            $display("FAIL final_idle: got wren=%0b addr=%h data=%h want 0/0/0",
                     mem_wren, mem_address, mem_data);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_dbg_store();
        test_starve();
        test_back_to_back();
        test_reset_inflight();
        test_reset_counter();
        test_starve_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
